// File: rtl/mem_arbiter_if.sv
// Block-transfer handshake bundle: one 128-bit block read or write per
// transaction, completed by a one-cycle ready pulse from the responder.
// The same bundle describes a cache port and the main-memory port.
interface mem_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   // Requester: issues the operation, receives data and the completion pulse.
   modport master (
      output read, write, addr, wdata,
      input  rdata, ready
   );

   // Responder: services the operation and returns data and the completion pulse.
   modport slave (
      input  read, write, addr, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow main-memory port between the I-cache
// and the D-cache. One transaction is in flight at a time: IDLE picks a
// requester and registers its operation onto the memory port, WAIT holds it
// until memory completes, RESP pulses the owner's ready for one cycle.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  i_port,
   mem_arbiter_if.slave  d_port,
   mem_arbiter_if.master mem
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   logic [1:0]        state;
   logic              owner;
   logic              last;

   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_ready_q;
   logic              d_ready_q;

   logic              i_req;
   logic              d_req;
   logic              grant_valid;
   logic              grant_port;
   logic              sel_read;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Grant decision and selection of the winning port's operation.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      i_req       = i_port.read | i_port.write;
      d_req       = d_port.read | d_port.write;
      grant_valid = i_req | d_req;
      grant_port  = PORT_I;
      if (i_req && d_req) begin
         grant_port = ~last;
      end else if (d_req) begin
         grant_port = PORT_D;
      end

      // Read+write together is illegal and is forwarded as a plain read.
      sel_read  = i_port.read;
      sel_write = i_port.write & ~i_port.read;
      sel_addr  = i_port.addr;
      sel_wdata = i_port.wdata;
      if (grant_port == PORT_D) begin
         sel_read  = d_port.read;
         sel_write = d_port.write & ~d_port.read;
         sel_addr  = d_port.addr;
         sel_wdata = d_port.wdata;
      end
   end

   // Transaction sequencer: grant, memory handshake, response pulse.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= PORT_I;
         last        <= PORT_I;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         // NOTE: the returned-data registers are wide, but they drive ports
         // that must read zero out of reset, so they are reset like control.
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner       <= grant_port;
                  mem_read_q  <= sel_read;
                  mem_write_q <= sel_write;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Requests are not re-sampled here; only memory completion matters.
               if (mem.ready) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (mem_read_q) begin
                     if (owner == PORT_D) begin
                        d_rdata_q <= mem.rdata;
                     end else begin
                        i_rdata_q <= mem.rdata;
                     end
                  end
                  if (owner == PORT_D) begin
                     d_ready_q <= 1'b1;
                  end else begin
                     i_ready_q <= 1'b1;
                  end
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               last  <= owner;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem.read     = mem_read_q;
   assign mem.write    = mem_write_q;
   assign mem.addr     = mem_addr_q;
   assign mem.wdata    = mem_wdata_q;

   assign i_port.rdata = i_rdata_q;
   assign i_port.ready = i_ready_q;
   assign d_port.rdata = d_rdata_q;
   assign d_port.ready = d_ready_q;

   // Invariants: one completion pulse at a time, never both memory strobes.
   a_one_ready : assert property (@(posedge clk) disable iff (rst)
      !(i_ready_q && d_ready_q));
   a_one_strobe : assert property (@(posedge clk) disable iff (rst)
      !(mem_read_q && mem_write_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two cache agents and a memory agent are
// driven from queues and $urandom; a transaction-level model predicts, per
// cycle, which port owns memory, what the memory strobes show, when each ready
// pulses and what each port's returned data must be.
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef enum int {OP_READ, OP_WRITE, OP_BOTH} op_e;
   typedef struct {
      op_e   op;
      addr_t addr;
      data_t wdata;
      bit    drop;
   } txn_t;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_port (i_bus),
      .d_port (d_bus),
      .mem    (m_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Stimulus state.
   txn_t  iq[$];
   txn_t  dq[$];
   txn_t  cur[2];
   bit    busy[2];
   bit    drv_req[2];
   bit    rst_drv;
   bit    rst_next;
   bit    rand_en;
   bit    spur_en;
   int    force_lat;
   int    lat_cnt;
   data_t mem_arr[addr_t];

   // Model state.
   bit    in_flight;
   int    owner_m;
   int    last_m;
   int    free_cyc;
   data_t exp_rdata[2];
   int    served[$];

   task automatic check(string tag, data_t got, data_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic data_t mem_val(addr_t a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {4{4'h0, a}};
   endfunction

   function automatic data_t rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   k;
      k       = int'($urandom_range(0, 9));
      t.op    = (k < 6) ? OP_READ : ((k < 9) ? OP_WRITE : OP_BOTH);
      t.addr  = addr_t'($urandom_range(0, 15));
      t.wdata = rand_data();
      t.drop  = ($urandom_range(0, 7) == 0);
      return t;
   endfunction

   function automatic txn_t mk(op_e op, addr_t a, data_t w, bit drop);
      txn_t t;
      t.op = op; t.addr = a; t.wdata = w; t.drop = drop;
      return t;
   endfunction

   function automatic int qsize(int p);
      return (p == 0) ? iq.size() : dq.size();
   endfunction

   task automatic push(int p, txn_t t);
      if (p == 0) iq.push_back(t);
      else        dq.push_back(t);
   endtask

   task automatic drive_ports();
      i_bus.read  = drv_req[0] && (cur[0].op != OP_WRITE);
      i_bus.write = drv_req[0] && (cur[0].op != OP_READ);
      i_bus.addr  = cur[0].addr;
      i_bus.wdata = cur[0].wdata;
      d_bus.read  = drv_req[1] && (cur[1].op != OP_WRITE);
      d_bus.write = drv_req[1] && (cur[1].op != OP_READ);
      d_bus.addr  = cur[1].addr;
      d_bus.wdata = cur[1].wdata;
   endtask

   // One clock: observe and check cycle outputs, then drive the next inputs.
   task automatic step();
      bit rdy[2];
      rdy[0] = 1'b0;
      rdy[1] = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_drv) begin
         in_flight    = 1'b0;
         last_m       = 0;
         free_cyc     = cyc;
         exp_rdata[0] = '0;
         exp_rdata[1] = '0;
         check("rst_mem_read",  data_t'(m_bus.read),  '0);
         check("rst_mem_write", data_t'(m_bus.write), '0);
         check("rst_mem_addr",  data_t'(m_bus.addr),  '0);
         check("rst_mem_wdata", m_bus.wdata,          '0);
         check("rst_i_ready",   data_t'(i_bus.ready), '0);
         check("rst_d_ready",   data_t'(d_bus.ready), '0);
         check("rst_i_rdata",   i_bus.rdata,          '0);
         check("rst_d_rdata",   d_bus.rdata,          '0);
      end else begin
         if (in_flight && m_bus.ready) begin
            // Memory completed last cycle: owner's ready pulses now.
            if (cur[owner_m].op != OP_WRITE) exp_rdata[owner_m] = mem_val(cur[owner_m].addr);
            rdy[owner_m]  = 1'b1;
            busy[owner_m] = 1'b0;
            in_flight     = 1'b0;
            last_m        = owner_m;
            free_cyc      = cyc + 1;
         end else if (!in_flight && (cyc - 1 >= free_cyc) && (drv_req[0] || drv_req[1])) begin
            // Arbiter was idle last cycle and saw requests: strobe appears now.
            if (drv_req[0] && drv_req[1]) owner_m = 1 - last_m;
            else                          owner_m = drv_req[1] ? 1 : 0;
            in_flight = 1'b1;
            lat_cnt   = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
         end
         check("mem_read",  data_t'(m_bus.read),  data_t'(in_flight && cur[owner_m].op != OP_WRITE));
         check("mem_write", data_t'(m_bus.write), data_t'(in_flight && cur[owner_m].op == OP_WRITE));
         if (in_flight) begin
            check("mem_addr",  data_t'(m_bus.addr), data_t'(cur[owner_m].addr));
            check("mem_wdata", m_bus.wdata,         cur[owner_m].wdata);
         end
         check("i_ready", data_t'(i_bus.ready), data_t'(rdy[0]));
         check("d_ready", data_t'(d_bus.ready), data_t'(rdy[1]));
         check("i_rdata", i_bus.rdata, exp_rdata[0]);
         check("d_rdata", d_bus.rdata, exp_rdata[1]);
         if (i_bus.ready) served.push_back(0);
         if (d_bus.ready) served.push_back(1);
      end

      // Inputs for this cycle.
      rst          = rst_next;
      rst_drv      = rst_next;
      m_bus.ready  = 1'b0;
      m_bus.rdata  = rand_data();
      if (rst_next) begin
         for (int p = 0; p < 2; p++) begin
            busy[p]    = 1'b0;
            drv_req[p] = 1'b0;
         end
         iq.delete();
         dq.delete();
         in_flight = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (in_flight && owner_m == p && cur[p].drop) drv_req[p] = 1'b0;
            if (rdy[p]) drv_req[p] = 1'b0;
            if (rand_en && !busy[p] && qsize(p) == 0 && $urandom_range(0, 2) == 0) push(p, rand_txn());
            if (!busy[p] && qsize(p) != 0) begin
               cur[p]     = (p == 0) ? iq.pop_front() : dq.pop_front();
               busy[p]    = 1'b1;
               drv_req[p] = 1'b1;
            end
         end
         if (in_flight) begin
            if (lat_cnt == 0) begin
               m_bus.ready = 1'b1;
               if (cur[owner_m].op != OP_WRITE) m_bus.rdata = mem_val(cur[owner_m].addr);
               else mem_arr[cur[owner_m].addr] = cur[owner_m].wdata;
            end else begin
               lat_cnt--;
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            // Memory pulses ready while the arbiter is idle or responding.
            m_bus.ready = 1'b1;
         end
      end
      drive_ports();
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_quiet(string tag, int budget);
      int n = 0;
      while ((busy[0] || busy[1] || in_flight || qsize(0) != 0 || qsize(1) != 0) && n < budget) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, data_t'(n >= budget), '0);
      run(2);
   endtask

   task automatic do_reset(int n);
      rst_next = 1'b1;
      run(n);
      rst_next = 1'b0;
      run(1);
   endtask

   initial begin
      rst       = 1'b1;
      rst_drv   = 1'b1;
      rst_next  = 1'b1;
      rand_en   = 1'b0;
      spur_en   = 1'b0;
      force_lat = -1;
      for (int p = 0; p < 2; p++) begin
         busy[p]    = 1'b0;
         drv_req[p] = 1'b0;
         cur[p]     = mk(OP_READ, '0, '0, 1'b0);
      end
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      drive_ports();
      do_reset(2);

      // Single I-cache read with a slow memory.
      mem_arr[addr_t'(28'h10)] = {16{8'hA5}};
      force_lat = 15;
      served.delete();
      push(0, mk(OP_READ, addr_t'(28'h10), '0, 1'b0));
      wait_quiet("i_read", 60);
      check("i_read_data", i_bus.rdata, {16{8'hA5}});
      check("i_read_served", data_t'(served.size()), data_t'(1));

      // D-cache write, then read it back.
      force_lat = 3;
      push(1, mk(OP_WRITE, addr_t'(28'h3), data_t'(128'h1234), 1'b0));
      wait_quiet("d_write", 40);
      check("d_write_rdata_kept", d_bus.rdata, '0);
      push(1, mk(OP_READ, addr_t'(28'h3), '0, 1'b0));
      wait_quiet("d_readback", 40);
      check("d_readback_data", d_bus.rdata, data_t'(128'h1234));

      // Tie right after reset: D first, and continued ties alternate.
      do_reset(2);
      force_lat = -1;
      served.delete();
      for (int k = 0; k < 3; k++) begin
         push(0, mk(OP_READ, addr_t'(k), '0, 1'b0));
         push(1, mk(OP_READ, addr_t'(k + 8), '0, 1'b0));
      end
      wait_quiet("alternate", 120);
      check("alt_count", data_t'(served.size()), data_t'(6));
      for (int k = 0; k < 6; k++) check("alt_order", data_t'(served[k]), data_t'((k % 2 == 0) ? 1 : 0));

      // Illegal read+write is forwarded as a read; owner drops request in WAIT.
      push(0, mk(OP_BOTH, addr_t'(28'h5), rand_data(), 1'b0));
      wait_quiet("illegal", 40);
      force_lat = 6;
      served.delete();
      push(0, mk(OP_READ, addr_t'(28'h10), '0, 1'b1));
      wait_quiet("drop", 40);
      check("drop_served", data_t'(served.size()), data_t'(1));

      // Spurious memory ready while idle.
      spur_en = 1'b1;
      run(12);

      // Reset during a long WAIT abandons the transaction.
      force_lat = 30;
      push(0, mk(OP_READ, addr_t'(28'h7), '0, 1'b0));
      run(5);
      check("abort_in_wait", data_t'(m_bus.read), data_t'(1));
      do_reset(2);
      force_lat = -1;
      served.delete();
      push(0, mk(OP_READ, addr_t'(28'h1), '0, 1'b0));
      push(1, mk(OP_READ, addr_t'(28'h2), '0, 1'b0));
      wait_quiet("post_abort_tie", 40);
      check("post_abort_first", data_t'(served[0]), data_t'(1));

      // Randomized traffic with spurious memory pulses.
      rand_en = 1'b1;
      run(3000);
      rand_en = 1'b0;
      wait_quiet("random_drain", 200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
